seg7_scan_driver: RTL and testbench

//  Parametrised, time-multiplexed hex driver for a DIGITS-wide 7-segment display on uo_out.

---
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a DIGITS-wide 7-segment display.
// Shadow-buffered updates land only on frame wrap; registered outputs with dead time.
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PRESCALE   = 1024,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  blank_lz_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic                  frame_done_o,
    output logic                  pending_o
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = $clog2(PRESCALE);

    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic              DP_OFF  = ACTIVE_LOW;

    logic [PW-1:0]     presc_q,   presc_d;
    logic [IW-1:0]     idx_q,     idx_d;
    logic [VW-1:0]     shadow_q,  shadow_d;
    logic [DIGITS-1:0] sdp_q,     sdp_d;
    logic [VW-1:0]     disp_q,    disp_d;
    logic [DIGITS-1:0] ddp_q,     ddp_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q,     seg_d;
    logic              dp_q,      dp_d;
    logic [DIGITS-1:0] en_q,      en_d;
    logic              fd_q,      fd_d;

    logic              tick, last, wrap;
    logic              zero_run, blank_here, blank, dp_sel;
    logic [3:0]        nib;
    logic [DIGITS-1:0] onehot;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan timing, shadow/display transfer and output decode
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        sdp_d      = sdp_q;
        disp_d     = disp_q;
        ddp_d      = ddp_q;
        pending_d  = pending_q;
        zero_run   = 1'b1;
        blank_here = 1'b0;
        dp_sel     = 1'b0;
        nib        = 4'h0;
        onehot     = '0;

        tick = (presc_q == PW'(PRESCALE - 1));
        last = (idx_q == IW'(DIGITS - 1));
        wrap = tick && last;

        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
            idx_d = last ? '0 : idx_q + IW'(1);
        end

        // A load coinciding with the wrap bypasses the shadow entirely
        if (load_i) begin
            shadow_d  = value_i;
            sdp_d     = dp_i;
            pending_d = !wrap;
            if (wrap) begin
                disp_d = value_i;
                ddp_d  = dp_i;
            end
        end else if (wrap && pending_q) begin
            disp_d    = shadow_q;
            ddp_d     = sdp_q;
            pending_d = 1'b0;
        end

        // Walk from the most significant digit down, tracking the leading-zero run
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                nib        = disp_q[4*k +: 4];
                blank_here = zero_run;
                dp_sel     = ddp_q[k];
                onehot[k]  = 1'b1;
            end
        end
        blank = blank_lz_i && (idx_q != '0) && blank_here;

        seg_d = (blank ? 7'h00 : hex7(nib)) ^ SEG_OFF;
        dp_d  = dp_sel ^ DP_OFF;
        en_d  = ((presc_q == '0) ? '0 : onehot) ^ EN_OFF;
        fd_d  = wrap;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            sdp_q     <= '0;
            disp_q    <= '0;
            ddp_q     <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            en_q      <= EN_OFF;
            fd_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            sdp_q     <= sdp_d;
            disp_q    <= disp_d;
            ddp_q     <= ddp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            en_q      <= en_d;
            fd_q      <= fd_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign digit_en_o   = en_q;
    assign frame_done_o = fd_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit active-high and an 8-digit active-low instance
// checked every cycle against a frame-arithmetic model, plus directed literal checks.
module tb_seg7_scan_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic [7:0]  dpin;
    logic        blz;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1, pend0, pend1;
    logic [3:0]  en0;
    logic [7:0]  en1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(P), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value[15:0]), .dp_i(dpin[3:0]),
        .blank_lz_i(blz), .seg_o(seg0), .dp_o(dp0), .digit_en_o(en0),
        .frame_done_o(fd0), .pending_o(pend0)
    );

    seg7_scan_driver #(.DIGITS(8), .PRESCALE(P), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .dp_i(dpin),
        .blank_lz_i(blz), .seg_o(seg1), .dp_o(dp1), .digit_en_o(en1),
        .frame_done_o(fd1), .pending_o(pend1)
    );

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: cycle count since reset drives slot/digit position arithmetically
    int          cyc;
    logic        mvalid = 1'b0;
    logic [31:0] m_shadow [2];
    logic [31:0] m_disp   [2];
    logic [7:0]  m_sdp    [2];
    logic [7:0]  m_ddp    [2];
    logic        m_pend   [2];
    logic [6:0]  e_seg    [2];
    logic        e_dp     [2];
    logic [7:0]  e_en     [2];
    logic        e_fd     [2];
    logic        e_pend   [2];

    always @(posedge clk) begin
        int          dg, p, d;
        bit          wr, blank;
        logic [3:0]  nib;
        logic [6:0]  s;
        logic [7:0]  en, dpm;
        logic        dv;
        logic [31:0] vin;
        if (rst) begin
            cyc = 0;
            for (int c = 0; c < 2; c++) begin
                m_shadow[c] = 0; m_disp[c] = 0; m_sdp[c] = 0; m_ddp[c] = 0; m_pend[c] = 0;
                e_seg[c] = (c == 1) ? 7'h7F : 7'h00;
                e_dp[c]  = (c == 1);
                e_en[c]  = (c == 1) ? 8'hFF : 8'h00;
                e_fd[c]  = 0;
                e_pend[c] = 0;
            end
            mvalid = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                dg  = (c == 1) ? 8 : 4;
                p   = cyc % P;
                d   = (cyc / P) % dg;
                wr  = (cyc % (P * dg)) == (P * dg - 1);
                vin = (c == 1) ? value : {16'h0, value[15:0]};
                dpm = (c == 1) ? dpin : {4'h0, dpin[3:0]};
                nib   = 4'((m_disp[c] >> (4 * d)) & 32'hF);
                blank = blz && (d > 0) && ((m_disp[c] >> (4 * d)) == 32'h0);
                s  = blank ? 7'h00 : HEX[nib];
                dv = m_ddp[c][d];
                en = (p == 0) ? 8'h00 : 8'(1 << d);
                if (c == 1) begin
                    s = ~s; dv = ~dv; en = ~en;
                end
                e_seg[c] = s;
                e_dp[c]  = dv;
                e_en[c]  = en;
                e_fd[c]  = wr;
                if (load) begin
                    m_shadow[c] = vin;
                    m_sdp[c]    = dpm;
                    if (wr) begin
                        m_disp[c] = vin; m_ddp[c] = dpm; m_pend[c] = 0;
                    end else begin
                        m_pend[c] = 1;
                    end
                end else if (wr && m_pend[c]) begin
                    m_disp[c] = m_shadow[c]; m_ddp[c] = m_sdp[c]; m_pend[c] = 0;
                end
                e_pend[c] = m_pend[c];
            end
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One negedge per cycle; every meaningful cycle is compared against the model
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mvalid) begin
                chk("m0_seg",  32'(seg0),  32'(e_seg[0]));
                chk("m0_dp",   32'(dp0),   32'(e_dp[0]));
                chk("m0_en",   32'(en0),   32'(e_en[0]));
                chk("m0_fd",   32'(fd0),   32'(e_fd[0]));
                chk("m0_pend", 32'(pend0), 32'(e_pend[0]));
                chk("m1_seg",  32'(seg1),  32'(e_seg[1]));
                chk("m1_dp",   32'(dp1),   32'(e_dp[1]));
                chk("m1_en",   32'(en1),   32'(e_en[1]));
                chk("m1_fd",   32'(fd1),   32'(e_fd[1]));
                chk("m1_pend", 32'(pend1), 32'(e_pend[1]));
            end
        end
    endtask

    task automatic wait_fd(input int c, input string name);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if ((c == 0) ? fd0 : fd1) found = 1;
        end
        chk({name, "_fd_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic wait_digit(input int c, input int k, input logic [6:0] es,
                              input logic edp, input string name);
        bit         found = 0;
        logic [7:0] target;
        target = (c == 0) ? 8'(1 << k) : ~8'(1 << k);
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if (((c == 0) ? {4'h0, en0} : en1) == target) found = 1;
        end
        chk({name, "_timeout"}, 32'(found), 32'd1);
        chk({name, "_seg"}, 32'((c == 0) ? seg0 : seg1), 32'(es));
        chk({name, "_dp"},  32'((c == 0) ? dp0 : dp1),   32'(edp));
    endtask

    initial begin
        int fcount;
        rst = 1; load = 0; value = 0; dpin = 0; blz = 0;

        // Reset state
        step(3);
        chk("rst_seg0", 32'(seg0), 32'h00);
        chk("rst_en0",  32'(en0),  32'h0);
        chk("rst_dp0",  32'(dp0),  32'h0);
        chk("rst_pend0", 32'(pend0), 32'h0);
        chk("rst_seg1", 32'(seg1), 32'h7F);
        chk("rst_en1",  32'(en1),  32'hFF);
        chk("rst_dp1",  32'(dp1),  32'h1);

        // First frame: dead-time cycle, then digit 0 lit showing 0
        rst = 0;
        step(1);
        chk("ff_dead_en0", 32'(en0), 32'h0);
        step(1);
        chk("ff_en0", 32'(en0), 32'h1);
        chk("ff_seg0", 32'(seg0), 32'h3F);
        fcount = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (fd0) fcount++;
        end
        chk("fd_count_32cyc", 32'(fcount), 32'd2);

        // Mid-frame load held in shadow until wrap
        wait_fd(0, "t2a");
        step(5);
        value = 32'h0000_12AF; load = 1;
        step(1);
        load = 0;
        chk("t2_pend_set", 32'(pend0), 32'h1);
        wait_fd(0, "t2b");
        chk("t2_pend_clr", 32'(pend0), 32'h0);
        wait_digit(0, 0, 7'h71, 1'b0, "t2_d0");
        wait_digit(0, 1, 7'h77, 1'b0, "t2_d1");
        wait_digit(0, 2, 7'h5B, 1'b0, "t2_d2");
        wait_digit(0, 3, 7'h06, 1'b0, "t2_d3");

        // Leading-zero blanking
        blz = 1;
        wait_fd(0, "t3a");
        step(3);
        value = 32'h0000_0005; load = 1;
        step(1);
        load = 0;
        wait_fd(0, "t3b");
        wait_digit(0, 0, 7'h6D, 1'b0, "t3_d0");
        wait_digit(0, 1, 7'h00, 1'b0, "t3_d1");
        wait_digit(0, 2, 7'h00, 1'b0, "t3_d2");
        wait_digit(0, 3, 7'h00, 1'b0, "t3_d3");
        value = 32'h0; load = 1;
        step(1);
        load = 0;
        wait_fd(0, "t3c");
        wait_digit(0, 0, 7'h3F, 1'b0, "t3z_d0");
        wait_digit(0, 1, 7'h00, 1'b0, "t3z_d1");
        blz = 0;

        // Back-to-back loads in one frame: last one wins
        wait_fd(0, "t4a");
        step(3);
        value = 32'h0000_1111; load = 1;
        step(1);
        value = 32'h0000_2222;
        step(1);
        load = 0;
        wait_fd(0, "t4b");
        for (int k = 0; k < 4; k++) wait_digit(0, k, 7'h5B, 1'b0, "t4_d");

        // Load on the wrapping tick goes straight to display
        wait_fd(0, "t5a");
        step(15);
        value = 32'h0000_ABCD; load = 1;
        step(1);
        load = 0;
        chk("t5_fd", 32'(fd0), 32'h1);
        chk("t5_pend", 32'(pend0), 32'h0);
        step(1);
        chk("t5_dead_en0", 32'(en0), 32'h0);
        step(1);
        chk("t5_d0_en", 32'(en0), 32'h1);
        chk("t5_d0_seg", 32'(seg0), 32'h5E);

        // Active-low 8-digit instance: decimal point on digit 7 only
        wait_fd(0, "t6a");
        step(5);
        value = 32'h0000_00A0; dpin = 8'h80; load = 1;
        step(1);
        load = 0; dpin = 8'h00;
        chk("t6_pend1", 32'(pend1), 32'h1);
        wait_fd(1, "t6b");
        wait_digit(1, 0, 7'h40, 1'b1, "t6_d0");
        wait_digit(1, 1, ~7'h77, 1'b1, "t6_d1");
        wait_digit(1, 7, 7'h40, 1'b0, "t6_d7");

        // Reset mid-frame aborts the scan at once
        step(6);
        rst = 1;
        step(1);
        chk("t6r_en1", 32'(en1), 32'hFF);
        chk("t6r_seg1", 32'(seg1), 32'h7F);
        chk("t6r_dp1", 32'(dp1), 32'h1);
        chk("t6r_en0", 32'(en0), 32'h0);
        rst = 0;
        step(2);
        chk("t6r_idx0_en0", 32'(en0), 32'h1);
        chk("t6r_idx0_en1", 32'(en1), 32'hFE);
        chk("t6r_seg0", 32'(seg0), 32'h3F);
        step(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
